bus_initiator: RTL and testbench
================================

Name: bus_initiator

Overview:
- Bridges a core-side command channel (valid/ready) onto the femto peripheral bus (req/resp/fault, addr, w_rb, acc, wdata/rdata).
- Acts as the initiator end facing bus responders such as the reset controller.
- Checks alignment, issues a one-cycle req, then waits for resp or fault under a timeout.
- Reports errors back to the core and, optionally, to the SoC fault inputs (soc_fault/soc_fault_cause/soc_fault_addr).

Parameters:
- TIMEOUT, 255: max WAIT cycles before a timeout error; 0 disables the timeout.
- FAULT_EN, 1: when 1, errors pulse soc_fault; when 0, soc_fault stays 0.
- CAUSE_MISALIGN, 8'h04: cause code for a misaligned access.
- CAUSE_BUS, 8'h05: cause code for a responder fault.
- CAUSE_TIMEOUT, 8'h06: cause code for a timeout.

Ports:
- clk  in  1  clock.
- rst_b  in  1  reset, asynchronous, active-low.
- c_req  in  1  command valid.
- c_rdy  out  1  command ready.
- c_addr  in  XLEN  command address.
- c_w_rb  in  1  1=write, 0=read.
- c_acc  in  BUS_ACC_WIDTH  access size: BUS_ACC_1B/2B/4B.
- c_wdata  in  BUS_WIDTH  write data.
- c_done  out  1  completion pulse.
- c_err  out  1  error flag, qualified by c_done.
- c_rdata  out  BUS_WIDTH  read data.
- addr  out  XLEN  bus address.
- w_rb  out  1  bus write/read.
- acc  out  BUS_ACC_WIDTH  bus access size.
- wdata  out  BUS_WIDTH  bus write data.
- req  out  1  bus request, one-cycle pulse.
- rdata  in  BUS_WIDTH  bus read data, valid with resp.
- resp  in  1  bus response.
- fault  in  1  bus fault, same cycle as req.
- soc_fault  out  1  fault report pulse.
- soc_fault_cause  out  8  fault cause.
- soc_fault_addr  out  XLEN  faulting address.

Behaviour:
Reset values:
- All registered outputs are 0 and the state is IDLE.
- c_rdy=1 while in reset.
- Asserting rst_b low mid-transaction drops the transaction immediately: req=0, no c_done, no soc_fault.

State IDLE:
- c_rdy=1.
- On c_req&c_rdy (cycle T), the command is registered onto addr/w_rb/acc/wdata.
- Misaligned command (2B with addr[0]!=0; 4B with addr[1:0]!=0): no req is issued; ERR is entered with CAUSE_MISALIGN.
- Aligned command: ISSUE is entered.
- resp and fault are ignored in IDLE. Late responses after a timeout are discarded here.

State ISSUE (one cycle, T+1):
- req=1.
- If fault=1: go to ERR with CAUSE_BUS. fault has priority over resp.
- Else if resp=1 (zero-latency responder): complete immediately.
- Else: go to WAIT with counter=0.

State WAIT:
- req=0.
- The counter increments each cycle; its width is clog2(TIMEOUT+1), and it saturates, never wrapping.
- resp=1: complete.
- Else if TIMEOUT!=0 and counter==TIMEOUT-1: go to ERR with CAUSE_TIMEOUT.
- resp and timeout in the same cycle: resp wins.
- Only resp and timeout are checked here; fault is not sampled in WAIT.

Completion (edge on which resp is seen):
- c_done=1 for one cycle, c_err=0.
- For reads, c_rdata<=rdata. For writes, c_rdata holds its previous value.
- State returns to IDLE on the same edge, so c_rdy=1 while c_done=1 and back-to-back commands are accepted.

State ERR (one cycle):
- c_done=1, c_err=1, c_rdata unchanged.
- If FAULT_EN: soc_fault=1 for exactly one cycle; soc_fault_cause=the cause; soc_fault_addr=the registered addr.
- soc_fault_cause and soc_fault_addr hold until the next error.
- Then IDLE.

Other rules:
- addr/w_rb/acc/wdata hold stable from ISSUE until the next accepted command.
- req is never asserted for more than one consecutive cycle per command.

Latency:
- Aligned command accepted at T: req at T+1.
- resp at T+1+N (N≥0): c_done at T+2+N.

Test Plan:
1. Read, acc=4B, addr=0x4; responder returns resp 1 cycle after req with rdata=0x12345678 -> req high exactly at T+1; c_done=1, c_err=0, c_rdata=0x12345678 at T+3.
2. Write, acc=2B, addr=0x0, wdata=0x1; responder asserts fault combinationally with req -> c_done=1, c_err=1; soc_fault single pulse with cause=8'h05, addr=0x0; no second req.
3. Read, acc=4B, addr=0x2 -> req never asserted; c_err=1; soc_fault_cause=8'h04, soc_fault_addr=0x2.
4. TIMEOUT=4, responder silent -> timeout error with cause=8'h06. A resp injected 2 cycles later is ignored: no c_done. The next command completes normally.
5. Responder resp arrives on the exact cycle the timeout would fire -> normal completion, c_err=0, soc_fault=0.
6. rst_b pulsed low during WAIT -> req=0, c_rdy=1, soc_fault=0, no c_done. Next command after release completes.

Source files
------------

// File: rtl/bus_initiator.sv
// bus_initiator: bridges a core valid/ready command channel onto the femto
// peripheral bus. It checks alignment, issues a one-cycle req, and then waits
// for resp under an optional timeout. Errors are reported to the core and,
// when enabled, to the SoC fault inputs.
module bus_initiator #(
    parameter int                       XLEN           = 32,
    parameter int                       BUS_WIDTH      = 32,
    parameter int                       BUS_ACC_WIDTH  = 2,
    parameter logic [BUS_ACC_WIDTH-1:0] BUS_ACC_1B     = BUS_ACC_WIDTH'(0),
    parameter logic [BUS_ACC_WIDTH-1:0] BUS_ACC_2B     = BUS_ACC_WIDTH'(1),
    parameter logic [BUS_ACC_WIDTH-1:0] BUS_ACC_4B     = BUS_ACC_WIDTH'(2),
    parameter int                       TIMEOUT        = 255,
    parameter bit                       FAULT_EN       = 1'b1,
    parameter logic [7:0]               CAUSE_MISALIGN = 8'h04,
    parameter logic [7:0]               CAUSE_BUS      = 8'h05,
    parameter logic [7:0]               CAUSE_TIMEOUT  = 8'h06
) (
    input  logic                     clk,
    input  logic                     rst_b,
    // core-side command channel
    input  logic                     c_req,
    output logic                     c_rdy,
    input  logic [XLEN-1:0]          c_addr,
    input  logic                     c_w_rb,
    input  logic [BUS_ACC_WIDTH-1:0] c_acc,
    input  logic [BUS_WIDTH-1:0]     c_wdata,
    output logic                     c_done,
    output logic                     c_err,
    output logic [BUS_WIDTH-1:0]     c_rdata,
    // femto bus
    output logic [XLEN-1:0]          addr,
    output logic                     w_rb,
    output logic [BUS_ACC_WIDTH-1:0] acc,
    output logic [BUS_WIDTH-1:0]     wdata,
    output logic                     req,
    input  logic [BUS_WIDTH-1:0]     rdata,
    input  logic                     resp,
    input  logic                     fault,
    // SoC fault report
    output logic                     soc_fault,
    output logic [7:0]               soc_fault_cause,
    output logic [XLEN-1:0]          soc_fault_addr
);

    // A zero TIMEOUT would give a zero-width counter, so keep at least one bit.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t         state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic           accept;
    logic           complete;
    logic           fail;
    logic [7:0]     fail_cause;
    logic [XLEN-1:0] fail_addr;

    function automatic logic misaligned(input logic [BUS_ACC_WIDTH-1:0] a,
                                        input logic [1:0]               lo);
        logic m;
        m = 1'b0;
        if (a == BUS_ACC_2B)      m = lo[0];
        else if (a == BUS_ACC_4B) m = |lo;
        else if (a == BUS_ACC_1B) m = 1'b0;
        return m;
    endfunction

    // Bus request and core ready are pure decodes of the state, so an async
    // reset drops them in the same instant.
    assign req   = (state == S_ISSUE);
    assign c_rdy = (state == S_IDLE);

    // Next-state decode plus the completion/error strobes for the datapath.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        complete   = 1'b0;
        fail       = 1'b0;
        fail_cause = 8'h00;
        fail_addr  = addr;
        unique case (state)
            S_IDLE: begin
                // resp and fault are ignored here, which discards late responses.
                if (c_req) begin
                    accept    = 1'b1;
                    fail_addr = c_addr;
                    if (misaligned(c_acc, c_addr[1:0])) begin
                        fail       = 1'b1;
                        fail_cause = CAUSE_MISALIGN;
                        state_next = S_ERR;
                    end else begin
                        state_next = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (fault) begin
                    fail       = 1'b1;
                    fail_cause = CAUSE_BUS;
                    state_next = S_ERR;
                end else if (resp) begin
                    complete   = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    cnt_next   = '0;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // fault is only meaningful alongside req, so it is not sampled here.
                if (resp) begin
                    complete   = 1'b1;
                    state_next = S_IDLE;
                end else if ((TIMEOUT != 0) && (32'(cnt) == 32'(TIMEOUT - 1))) begin
                    fail       = 1'b1;
                    fail_cause = CAUSE_TIMEOUT;
                    state_next = S_ERR;
                end else if (cnt != CNT_MAX) begin
                    cnt_next = cnt + 1'b1;
                end
            end
            S_ERR: begin
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State register and wait counter.
    always_ff @(posedge clk or negedge rst_b) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_b) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Command capture, completion/error reporting and read-data return.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            addr            <= '0;
            w_rb            <= 1'b0;
            acc             <= '0;
            wdata           <= '0;
            c_done          <= 1'b0;
            c_err           <= 1'b0;
            c_rdata         <= '0;
            soc_fault       <= 1'b0;
            soc_fault_cause <= 8'h00;
            soc_fault_addr  <= '0;
        end else begin
            if (accept) begin
                addr  <= c_addr;
                w_rb  <= c_w_rb;
                acc   <= c_acc;
                wdata <= c_wdata;
            end
            c_done    <= complete | fail;
            c_err     <= fail;
            soc_fault <= FAULT_EN & fail;
            if (complete && !w_rb) begin
                c_rdata <= rdata;
            end
            if (FAULT_EN && fail) begin
                soc_fault_cause <= fail_cause;
                soc_fault_addr  <= fail_addr;
            end
        end
    end

endmodule

// File: tb/tb_bus_initiator.sv
// Directed testbench for bus_initiator with TIMEOUT=4. Inputs change 1 ns
// after the rising edge and outputs are checked at the same point.
module tb_bus_initiator;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        c_req;
    logic        c_rdy;
    logic [31:0] c_addr;
    logic        c_w_rb;
    logic [1:0]  c_acc;
    logic [31:0] c_wdata;
    logic        c_done;
    logic        c_err;
    logic [31:0] c_rdata;
    logic [31:0] addr;
    logic        w_rb;
    logic [1:0]  acc;
    logic [31:0] wdata;
    logic        req;
    logic [31:0] rdata;
    logic        resp;
    logic        fault;
    logic        fault_mode;
    logic        soc_fault;
    logic [7:0]  soc_fault_cause;
    logic [31:0] soc_fault_addr;

    int total = 0;
    int bad   = 0;

    // Responder model that raises fault in the same cycle as req.
    assign fault = fault_mode & req;

    always #5 clk = ~clk;

    bus_initiator #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_b(rst_b),
        .c_req(c_req), .c_rdy(c_rdy), .c_addr(c_addr), .c_w_rb(c_w_rb),
        .c_acc(c_acc), .c_wdata(c_wdata), .c_done(c_done), .c_err(c_err),
        .c_rdata(c_rdata),
        .addr(addr), .w_rb(w_rb), .acc(acc), .wdata(wdata), .req(req),
        .rdata(rdata), .resp(resp), .fault(fault),
        .soc_fault(soc_fault), .soc_fault_cause(soc_fault_cause),
        .soc_fault_addr(soc_fault_addr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic command(input logic [31:0] a, input logic w, input logic [1:0] sz,
                           input logic [31:0] d);
        c_req   = 1'b1;
        c_addr  = a;
        c_w_rb  = w;
        c_acc   = sz;
        c_wdata = d;
    endtask

    initial begin
        rst_b = 1'b0; c_req = 1'b0; c_addr = '0; c_w_rb = 1'b0; c_acc = '0;
        c_wdata = '0; rdata = '0; resp = 1'b0; fault_mode = 1'b0;

        // Reset state
        #2;
        check("rst_rdy", c_rdy, 1);
        check("rst_req", req, 0);
        check("rst_done", c_done, 0);
        check("rst_soc_fault", soc_fault, 0);
        tick(); tick();
        rst_b = 1'b1;
        tick();

        // 1: aligned 4B read, resp one cycle after req
        command(32'h4, 1'b0, 2'd2, 32'h0);
        check("t1_rdy_T", c_rdy, 1);
        tick();                                   // T+1
        c_req = 1'b0;
        check("t1_req_T1", req, 1);
        check("t1_addr", addr, 32'h4);
        tick();                                   // T+2
        check("t1_req_T2", req, 0);
        resp = 1'b1; rdata = 32'h12345678;
        tick();                                   // T+3
        resp = 1'b0; rdata = '0;
        check("t1_done", c_done, 1);
        check("t1_err", c_err, 0);
        check("t1_rdata", c_rdata, 32'h12345678);
        check("t1_rdy_with_done", c_rdy, 1);
        tick();
        check("t1_done_pulse", c_done, 0);

        // 2: 2B write, responder faults alongside req
        fault_mode = 1'b1;
        command(32'h0, 1'b1, 2'd1, 32'h1);
        tick();                                   // T+1
        c_req = 1'b0;
        check("t2_req_T1", req, 1);
        check("t2_wdata", wdata, 32'h1);
        tick();                                   // T+2
        check("t2_done", c_done, 1);
        check("t2_err", c_err, 1);
        check("t2_soc_fault", soc_fault, 1);
        check("t2_cause", soc_fault_cause, 32'h05);
        check("t2_faddr", soc_fault_addr, 32'h0);
        check("t2_req_T2", req, 0);
        check("t2_rdata_hold", c_rdata, 32'h12345678);
        tick();                                   // T+3
        check("t2_soc_fault_pulse", soc_fault, 0);
        check("t2_req_T3", req, 0);
        check("t2_cause_hold", soc_fault_cause, 32'h05);
        fault_mode = 1'b0;

        // 3: misaligned 4B read
        command(32'h2, 1'b0, 2'd2, 32'h0);
        tick();                                   // T+1
        c_req = 1'b0;
        check("t3_req_T1", req, 0);
        check("t3_done", c_done, 1);
        check("t3_err", c_err, 1);
        check("t3_soc_fault", soc_fault, 1);
        check("t3_cause", soc_fault_cause, 32'h04);
        check("t3_faddr", soc_fault_addr, 32'h2);
        tick();                                   // T+2
        check("t3_req_T2", req, 0);
        check("t3_soc_fault_pulse", soc_fault, 0);
        check("t3_rdy", c_rdy, 1);

        // 4: silent responder, timeout after four WAIT cycles
        command(32'h8, 1'b0, 2'd2, 32'h0);
        tick();                                   // T+1
        c_req = 1'b0;
        check("t4_req_T1", req, 1);
        for (int i = 0; i < 4; i++) begin
            tick();                               // T+2 .. T+5
            check("t4_wait_no_done", c_done, 0);
            check("t4_wait_no_req", req, 0);
        end
        tick();                                   // T+6
        check("t4_done", c_done, 1);
        check("t4_err", c_err, 1);
        check("t4_soc_fault", soc_fault, 1);
        check("t4_cause", soc_fault_cause, 32'h06);
        check("t4_faddr", soc_fault_addr, 32'h8);
        tick();                                   // back in IDLE
        resp = 1'b1; rdata = 32'hDEADBEEF;        // late response
        tick();
        resp = 1'b0; rdata = '0;
        check("t4_late_no_done", c_done, 0);
        check("t4_late_rdata", c_rdata, 32'h12345678);
        // follow-up command with a zero-latency responder
        command(32'hC, 1'b0, 2'd2, 32'h0);
        tick();                                   // T'+1
        c_req = 1'b0;
        check("t4_next_req", req, 1);
        resp = 1'b1; rdata = 32'hCAFEF00D;
        tick();                                   // T'+2
        resp = 1'b0; rdata = '0;
        check("t4_next_done", c_done, 1);
        check("t4_next_err", c_err, 0);
        check("t4_next_rdata", c_rdata, 32'hCAFEF00D);

        // 5: resp on the exact cycle the timeout would fire
        command(32'h10, 1'b0, 2'd2, 32'h0);
        tick();                                   // T+1
        c_req = 1'b0;
        tick(); tick(); tick();                   // T+2 .. T+4
        check("t5_no_done_T4", c_done, 0);
        tick();                                   // T+5
        resp = 1'b1; rdata = 32'hA5A55A5A;
        tick();                                   // T+6
        resp = 1'b0; rdata = '0;
        check("t5_done", c_done, 1);
        check("t5_err", c_err, 0);
        check("t5_soc_fault", soc_fault, 0);
        check("t5_rdata", c_rdata, 32'hA5A55A5A);
        check("t5_cause_hold", soc_fault_cause, 32'h06);

        // 6: reset pulse during WAIT
        command(32'h14, 1'b0, 2'd2, 32'h0);
        tick();                                   // T+1
        c_req = 1'b0;
        check("t6_req_T1", req, 1);
        tick(); tick();                           // WAIT
        rst_b = 1'b0;
        #1;
        check("t6_rst_req", req, 0);
        check("t6_rst_rdy", c_rdy, 1);
        check("t6_rst_soc_fault", soc_fault, 0);
        check("t6_rst_done", c_done, 0);
        check("t6_rst_addr", addr, 32'h0);
        tick(); tick();
        check("t6_rst_hold_done", c_done, 0);
        rst_b = 1'b1;
        tick();
        check("t6_after_done", c_done, 0);
        check("t6_after_cause", soc_fault_cause, 32'h0);
        command(32'h18, 1'b1, 2'd2, 32'h55AA55AA);
        tick();                                   // T+1
        c_req = 1'b0;
        check("t6_next_req", req, 1);
        check("t6_next_wdata", wdata, 32'h55AA55AA);
        resp = 1'b1; rdata = 32'h11111111;
        tick();                                   // T+2
        resp = 1'b0; rdata = '0;
        check("t6_next_done", c_done, 1);
        check("t6_next_err", c_err, 0);
        check("t6_write_rdata_hold", c_rdata, 32'h0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
